// File: rtl/wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_pkg : shared widths and queue entry type for the write-back path   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package wb_pkg;
  localparam int DW           = 32;
  localparam int AW           = 5;
  localparam int WB_DEPTH_DEF = 4;

  typedef struct packed {
    logic          live;
    logic [AW-1:0] reg_idx;
    logic [DW-1:0] data;
  } wb_entry_t;
endpackage
`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_queue : in-order load-result circular buffer with kill-by-register |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEF,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  wb_entry_t               push_entry,
  input  logic                    pop,
  input  logic                    kill_en,
  input  logic [AW-1:0]           kill_reg,
  output logic                    full,
  output logic                    empty,
  output wb_entry_t               head,
  output wb_entry_t [DEPTH-1:0]   entries,
  output logic [PW-1:0]           head_ptr
);
  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [PW:0]           count_q, count_d;
  logic                  do_push, do_pop;

  assign full     = (count_q == (PW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head     = mem_q[head_q];
  assign entries  = mem_q;
  assign head_ptr = head_q;

  // Kill first, then retire the head, then write the new tail: a load
  // accepted alongside a killing ALU write is younger and stays live.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_en && mem_q[i].reg_idx == kill_reg) mem_d[i].live = 1'b0;
    end
    if (do_pop)  mem_d[head_q].live = 1'b0;
    if (do_push) mem_d[tail_q] = push_entry;
    head_d  = do_pop  ? head_q + PW'(1) : head_q;
    tail_d  = do_push ? tail_q + PW'(1) : tail_q;
    count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule
`default_nettype wire

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_write_arbiter : merges ALU and queued load results onto the single |
// | register-file write port. Forwarding search enabled by WB_FWD_EN.     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEF,
  parameter int DW    = wb_pkg::DW,
  parameter int AW    = wb_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_reg,
  input  logic [DW-1:0] alu_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_reg,
  input  logic [DW-1:0] ld_data,
  output logic          enwrite,
  output logic [AW-1:0] writereg,
  output logic [DW-1:0] writedata,
  input  logic [AW-1:0] fwd_reg1,
  input  logic [AW-1:0] fwd_reg2,
  output logic          fwd_hit1,
  output logic          fwd_hit2,
  output logic [DW-1:0] fwd_data1,
  output logic [DW-1:0] fwd_data2
);
  localparam int PW = $clog2(DEPTH);

  logic                  alu_issue, q_push, q_pop, q_full, q_empty;
  wb_entry_t             q_head, q_push_entry;
  wb_entry_t [DEPTH-1:0] q_entries;
  logic [PW-1:0]         q_head_ptr;
  logic                  enwrite_q, enwrite_d;
  logic [AW-1:0]         writereg_q, writereg_d;
  logic [DW-1:0]         writedata_q, writedata_d;

  assign alu_issue    = alu_valid && (alu_reg != '0);
  assign ld_ready     = !q_full;
  assign q_push       = ld_valid && !q_full && (ld_reg != '0);
  assign q_pop        = !alu_issue && !q_empty;
  assign q_push_entry = '{live: 1'b1, reg_idx: ld_reg, data: ld_data};

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (q_push),
    .push_entry (q_push_entry),
    .pop        (q_pop),
    .kill_en    (alu_issue),
    .kill_reg   (alu_reg),
    .full       (q_full),
    .empty      (q_empty),
    .head       (q_head),
    .entries    (q_entries),
    .head_ptr   (q_head_ptr)
  );

  always_comb begin
    enwrite_d   = 1'b0;
    writereg_d  = '0;
    writedata_d = '0;
    if (alu_issue) begin
      enwrite_d   = 1'b1;
      writereg_d  = alu_reg;
      writedata_d = alu_data;
    end else if (!q_empty && q_head.live) begin
      enwrite_d   = 1'b1;
      writereg_d  = q_head.reg_idx;
      writedata_d = q_head.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enwrite_q   <= 1'b0;
      writereg_q  <= '0;
      writedata_q <= '0;
    end else begin
      enwrite_q   <= enwrite_d;
      writereg_q  <= writereg_d;
      writedata_q <= writedata_d;
    end
  end

  assign enwrite   = enwrite_q;
  assign writereg  = writereg_q;
  assign writedata = writedata_q;

`ifdef WB_FWD_EN
  // Walk from oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = q_head_ptr + PW'(i);
      if (q_entries[idx].live && fwd_reg1 != '0 && q_entries[idx].reg_idx == fwd_reg1) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = q_entries[idx].data;
      end
      if (q_entries[idx].live && fwd_reg2 != '0 && q_entries[idx].reg_idx == fwd_reg2) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = q_entries[idx].data;
      end
    end
  end
`else
  logic fwd_unused;
  assign fwd_unused = ^{q_entries, q_head_ptr, fwd_reg1, fwd_reg2};
  assign fwd_hit1   = 1'b0;
  assign fwd_hit2   = 1'b0;
  assign fwd_data1  = '0;
  assign fwd_data2  = '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// Directed bench for wb_write_arbiter; a scoreboard holds the register-file
// writes expected in order and a negedge monitor retires them.
module tb_wb_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, ld_valid, ld_ready, enwrite;
  logic [AW-1:0] alu_reg, ld_reg, writereg, fwd_reg1, fwd_reg2;
  logic [DW-1:0] alu_data, ld_data, writedata, fwd_data1, fwd_data2;
  logic          fwd_hit1, fwd_hit2;

  int checks = 0;
  int passes = 0;
  logic [AW+DW-1:0] sb[$];
  logic [AW+DW-1:0] pend[$];

  wb_write_arbiter #(.DEPTH(4), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_reg(ld_reg), .ld_data(ld_data),
    .enwrite(enwrite), .writereg(writereg), .writedata(writedata),
    .fwd_reg1(fwd_reg1), .fwd_reg2(fwd_reg2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Every write the DUT makes must be the next one the bench expects.
  always @(negedge clk) begin
    if (enwrite) begin
      checks++;
      assert (sb.size() != 0) passes++;
      else $error("FAIL unexpected_write: observed r%0d=0x%0h expected none", writereg, writedata);
      if (sb.size() != 0) begin
        logic [AW+DW-1:0] exp;
        exp = sb.pop_front();
        checks++;
        assert ({writereg, writedata} === exp) passes++;
        else $error("FAIL write: observed r%0d=0x%0h expected r%0d=0x%0h",
                    writereg, writedata, exp[AW+DW-1:DW], exp[DW-1:0]);
      end
    end
  end

  initial begin
    rst = 1'b1; alu_valid = 0; alu_reg = 0; alu_data = 0;
    ld_valid = 0; ld_reg = 0; ld_data = 0; fwd_reg1 = 0; fwd_reg2 = 0;
    #2;
    chk("rst_enwrite", 64'(enwrite), 64'd0);
    chk("rst_writereg", 64'(writereg), 64'd0);
    chk("rst_writedata", 64'(writedata), 64'd0);
    chk("rst_ld_ready", 64'(ld_ready), 64'd1);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // ALU-only path
    alu_valid = 1; alu_reg = 5; alu_data = 32'hAA; sb.push_back({5'd5, 32'hAA});
    cyc();
    alu_valid = 0;
    chk("alu_en_k", 64'(enwrite), 64'd1);
    cyc();
    chk("alu_en_k1", 64'(enwrite), 64'd0);

    // Load latency: two edges
    ld_valid = 1; ld_reg = 9; ld_data = 32'h1234; sb.push_back({5'd9, 32'h1234});
    cyc();
    ld_valid = 0;
    chk("ld_en_k", 64'(enwrite), 64'd0);
    cyc();
    chk("ld_en_k1", 64'(enwrite), 64'd1);
    cyc();
    chk("ld_en_k2", 64'(enwrite), 64'd0);

    // Back-pressure: ALU r1 every cycle starves the queue
    for (int i = 0; i < 5; i++) begin
      alu_valid = 1; alu_reg = 1; alu_data = 32'hA0 + i;
      sb.push_back({5'd1, 32'hA0 + 32'(i)});
      ld_valid = 1; ld_reg = 5'(10 + i); ld_data = 32'h100 + i;
      chk($sformatf("bp_ready_%0d", i), 64'(ld_ready), (i < 4) ? 64'd1 : 64'd0);
      if (i < 4) pend.push_back({5'(10 + i), 32'h100 + 32'(i)});
      cyc();
    end
    ld_valid = 0; alu_valid = 0;
    while (pend.size() != 0) sb.push_back(pend.pop_front());
    cyc();
    chk("bp_ready_after_pop", 64'(ld_ready), 64'd1);
    cyc(); cyc(); cyc();
    cyc();
    chk("bp_drained", 64'(enwrite), 64'd0);

    // Kill rule
    ld_valid = 1; ld_reg = 7; ld_data = 32'h11;
    cyc();
    ld_valid = 0; alu_valid = 1; alu_reg = 7; alu_data = 32'h22; sb.push_back({5'd7, 32'h22});
    cyc();
    alu_valid = 0;
    chk("kill_alu_en", 64'(enwrite), 64'd1);
    cyc();
    chk("kill_dead_pop", 64'(enwrite), 64'd0);
    cyc();
    chk("kill_empty", 64'(enwrite), 64'd0);

    // Load accepted on the killing edge stays live
    alu_valid = 1; alu_reg = 7; alu_data = 32'h44; sb.push_back({5'd7, 32'h44});
    ld_valid = 1; ld_reg = 7; ld_data = 32'h33; sb.push_back({5'd7, 32'h33});
    cyc();
    alu_valid = 0; ld_valid = 0;
    cyc();
    chk("young_ld_en", 64'(enwrite), 64'd1);
    cyc();
    chk("young_ld_done", 64'(enwrite), 64'd0);

    // r0 handling
    ld_valid = 1; ld_reg = 0; ld_data = 32'hFF;
    alu_valid = 1; alu_reg = 0; alu_data = 32'hFF;
    chk("r0_ready", 64'(ld_ready), 64'd1);
    cyc();
    ld_valid = 0; alu_valid = 0;
    chk("r0_en_a", 64'(enwrite), 64'd0);
    cyc();
    chk("r0_en_b", 64'(enwrite), 64'd0);
    ld_valid = 1; ld_reg = 8; ld_data = 32'h55; sb.push_back({5'd8, 32'h55});
    cyc();
    ld_valid = 0; alu_valid = 1; alu_reg = 0; alu_data = 32'h99;
    cyc();
    alu_valid = 0;
    chk("r0_alu_frees_slot", 64'(enwrite), 64'd1);
    cyc();

    // Forwarding: two loads to r3 held behind ALU traffic
    alu_valid = 1; alu_reg = 1; alu_data = 32'hB0; sb.push_back({5'd1, 32'hB0});
    ld_valid = 1; ld_reg = 3; ld_data = 32'h10;
    cyc();
    alu_data = 32'hB1; sb.push_back({5'd1, 32'hB1});
    ld_data = 32'h20;
    cyc();
    ld_valid = 0; alu_data = 32'hB2; sb.push_back({5'd1, 32'hB2});
    fwd_reg1 = 3; fwd_reg2 = 4;
    #1;
`ifdef WB_FWD_EN
    chk("fwd_hit1", 64'(fwd_hit1), 64'd1);
    chk("fwd_data1", 64'(fwd_data1), 64'h20);
`else
    chk("fwd_hit1", 64'(fwd_hit1), 64'd0);
    chk("fwd_data1", 64'(fwd_data1), 64'd0);
`endif
    chk("fwd_hit2", 64'(fwd_hit2), 64'd0);
    chk("fwd_data2", 64'(fwd_data2), 64'd0);
    cyc();
    fwd_reg1 = 0;
    #1;
    chk("fwd_r0_miss", 64'(fwd_hit1), 64'd0);
    alu_valid = 0;
    sb.push_back({5'd3, 32'h10});
    sb.push_back({5'd3, 32'h20});
    cyc(); cyc();
    cyc();
    chk("fwd_drained", 64'(enwrite), 64'd0);

    // Reset mid-drain: queued loads must never appear
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_reg = 1; alu_data = 32'hC0 + i;
      sb.push_back({5'd1, 32'hC0 + 32'(i)});
      ld_valid = 1; ld_reg = 5'(20 + i); ld_data = 32'h200 + i;
      cyc();
    end
    ld_valid = 0;
    @(negedge clk);
    #1;
    rst = 1; alu_valid = 0;
    #1;
    chk("mid_rst_enwrite", 64'(enwrite), 64'd0);
    chk("mid_rst_ready", 64'(ld_ready), 64'd1);
    cyc();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("post_rst_en_%0d", i), 64'(enwrite), 64'd0);
    end

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Write-back arbiter that drives the single write port of the 32x32 register file (`enwrite`, `writereg`, `writedata`). It merges a never-stalled ALU result stream with a variable-latency load-result stream. Load results are buffered in a small in-order queue and drained into free write slots. Optional forwarding outputs let the decode stage read values that are still queued.

## Interface
- `DEPTH`, 4: load queue entries; power of two, at least 2.
- `DW`, 32: data width.
- `AW`, 5: register index width.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `alu_valid` in 1: ALU result present this cycle; never back-pressured.
- `alu_reg` in AW: ALU destination register.
- `alu_data` in DW: ALU result.
- `ld_valid` in 1: load result offered.
- `ld_ready` out 1: queue can accept; equals `!full`.
- `ld_reg` in AW: load destination register.
- `ld_data` in DW: load data.
- `enwrite` out 1: register-file write enable; registered.
- `writereg` out AW: register-file write index; registered.
- `writedata` out DW: register-file write data; registered.
- `fwd_reg1`, `fwd_reg2` in AW: forwarding lookup indices.
- `fwd_hit1`, `fwd_hit2` out 1: a live queued entry matches the lookup index.
- `fwd_data1`, `fwd_data2` out DW: data of the youngest matching entry.

## Operation
- **Load accept.** A load is accepted on an edge where `ld_valid && ld_ready`.
  - `ld_reg == 0`: accepted, then discarded (not enqueued).
  - Otherwise: pushed at the tail with `live = 1`.
- **Arbitration** (combinational, each cycle; result registered at the next edge):
  1. `alu_valid && alu_reg != 0`: issue the ALU write.
  2. Otherwise, queue non-empty and head live: pop the head and issue it.
  3. Otherwise, head not live: pop the head and issue nothing (`enwrite = 0`).
  4. Otherwise (nothing pending): `enwrite = 0`.
- **ALU to r0.** `alu_valid` with `alu_reg == 0` is dropped. It frees the slot, so the queue may drain in that cycle.
- **Kill rule.** When an ALU write to X is issued, every queued entry with `reg == X` is cleared to `live = 0`, because the ALU result is younger. This happens on the same edge. A load accepted on that same edge with `ld_reg == X` is enqueued live, since it is younger than the ALU result.
- **Push and pop on the same edge.** Allowed. The count is unchanged.
- **ld_ready when full.** `ld_ready` reflects only the current count; there is no pass-through when full.
- **Pointers.** Head and tail pointers wrap modulo `DEPTH`. The count is `clog2(DEPTH)+1` bits wide.
- **Reset.**
  - Asserting `rst` at any time, including mid-drain, clears the queue (count 0, pointers 0, all entries not live).
  - Reset values: `enwrite = 0`, `writereg = 0`, `writedata = 0`, `ld_ready = 1`.
- **Forwarding.**
  - `fwd_hitN = 1` when `fwd_regN != 0` and at least one queued entry is live with matching `reg`.
  - `fwd_dataN` is the data of the youngest such entry; it is 0 when there is no hit.
  - Outputs are combinational from queue state only. Entries accepted on the current edge and the output register are not searched.

## Timing
- **ALU latency.** `alu_valid` sampled at edge k gives `enwrite = 1` from edge k through edge k+1.
- **Load latency.** A load sampled at edge k, with the queue empty and no ALU activity, gives `enwrite = 1` after edge k+1 (2 edges).
- **Drain under ALU traffic.** Continuous `alu_valid` starves the queue indefinitely. Draining resumes on the first cycle without a valid, non-r0 ALU result.
- **Throughput.** At most one register-file write per cycle.
- **Dead slots.** Killed entries cost one cycle each to pop.
- **Fullness.**
  - `ld_ready` deasserts in the cycle the count reaches `DEPTH`.
  - It reasserts in the cycle after a pop lowers the count.

## Configuration
- **`WB_FWD_EN` defined:** the forwarding comparators and the youngest-match priority logic are compiled in, as described above.
- **`WB_FWD_EN` undefined:** `fwd_hit1`, `fwd_hit2`, `fwd_data1` and `fwd_data2` are tied to 0. The ports remain present and the queue behaves identically.

## Structure
- **Shared package `wb_pkg`.**
  - Constants `DW`, `AW`, `WB_DEPTH_DEF`.
  - Typedef `wb_entry_t` with fields `live`, `reg` [AW], `data` [DW].
- **Sub-module `wb_queue`.**
  - Circular buffer with push and pop.
  - Kill-by-register-match input.
  - `full`/`empty` outputs and head-entry output.
  - Entry-array export for the forwarding search.
- **Top level** holds the arbiter, the output registers and the forwarding muxes.

## Test plan
- **Reset mid-drain.** Queue 3 loads, assert `rst` for 1 cycle -> `enwrite = 0`, `ld_ready = 1`; no queued write ever appears afterwards.
- **ALU-only path.** `alu_valid` with r5 = 0x0000_00AA at edge k -> `enwrite = 1`, `writereg = 5`, `writedata = 0xAA` after edge k; `enwrite = 0` after edge k+1.
- **Back-pressure.** Hold `alu_valid` (r1) while pushing 5 loads with `DEPTH = 4` -> `ld_ready = 0` after the 4th accept. Dropping `alu_valid` drains r-indices in order, one per cycle.
- **Kill rule.** Queue a load to r7 = 0x11, then an ALU write to r7 = 0x22 -> only 0x22 is written to r7. The killed entry pops with `enwrite = 0`.
- **r0 handling.** Load to r0 = 0xFF and ALU to r0 -> no `enwrite` pulse; the load is still accepted.
- **Forwarding.** With `WB_FWD_EN`, queue r3 = 0x10 then r3 = 0x20 and look up `fwd_reg1 = 3` -> `fwd_hit1 = 1`, `fwd_data1 = 0x20`. Without the macro -> `fwd_hit1 = 0`.
